// File: rtl/pe_au_pkg.sv
// pe_au_pkg: DSP48E2 OPMODE encodings, sequencer states and the alignment-pipe entry type
// shared by the PE arithmetic-unit sequencer and its delay pipe.
package pe_au_pkg;

  typedef logic [8:0] opmode_t;

  // {W,Z,Y,X}
  localparam opmode_t OP_HOLD  = 9'b00_010_00_00;
  localparam opmode_t OP_MC    = 9'b11_000_01_01;
  localparam opmode_t OP_MPC   = 9'b00_001_01_01;
  localparam opmode_t OP_MCSH  = 9'b11_110_01_01;
  localparam opmode_t OP_CARRY = 9'b00_110_00_00;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} seq_state_t;

  typedef struct packed {
    opmode_t op;
    logic    uses_c;
    logic    valid;
    logic    last;
  } pipe_ent_t;

  localparam pipe_ent_t ENT_IDLE = '{op: OP_HOLD, uses_c: 1'b0, valid: 1'b0, last: 1'b0};

endpackage

// File: rtl/pe_au_align_pipe.sv
// pe_au_align_pipe: (LAT+1)-deep shift of {op, uses_c, valid, last}; taps each field at the
// cycle the DSP consumes it (OPMODE at LAT, C enable at C_TAP, P flags at LAT+1).
module pe_au_align_pipe
  import pe_au_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int C_TAP = 1
) (
  input  logic       clock_i,
  input  logic       reset_n_i,
  input  pipe_ent_t  ent_i,
  output logic [8:0] op_o,
  output logic       uses_c_o,
  output logic       valid_o,
  output logic       last_o,
  output logic       busy_o
);

  pipe_ent_t [LAT:0] stage_q, stage_d;

  always_comb begin
    stage_d[0] = ent_i;
    for (int k = 1; k <= LAT; k++) stage_d[k] = stage_q[k-1];
  end

  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) stage_q <= {(LAT+1){ENT_IDLE}};
    else stage_q <= stage_d;

  // Tap 0 is the entry being issued this cycle, so a zero offset is combinational.
  if (LAT > 0) begin : g_op
    assign op_o = stage_q[LAT-1].op;
  end else begin : g_op_now
    assign op_o = ent_i.op;
  end

  if (C_TAP > 0) begin : g_c
    assign uses_c_o = stage_q[C_TAP-1].uses_c;
  end else begin : g_c_now
    assign uses_c_o = ent_i.uses_c;
  end

  assign valid_o = stage_q[LAT].valid;
  assign last_o  = stage_q[LAT].valid & stage_q[LAT].last;
  // Bubbles are stored as ENT_IDLE, so anything else in flight means a pending op.
  assign busy_o  = stage_q != {(LAT+1){ENT_IDLE}};

endmodule

// File: rtl/pe_au_sequencer.sv
// pe_au_sequencer: FIOS PE arithmetic-unit controller; walks round i / word j, requests
// operands and emits DSP OPMODE, C enable and result flags aligned to the A/B/M pipeline.
module pe_au_sequencer
  import pe_au_pkg::*;
#(
  parameter int WORDS   = 16,
  parameter int ABREG   = 1,
  parameter int MREG    = 1,
  parameter int CREG    = 1,
  parameter int CASCADE = 0
) (
  input  logic                     clock_i,
  input  logic                     reset_n_i,
  input  logic                     start_i,
  input  logic                     operand_rdy_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     issue_o,
  output logic [$clog2(WORDS)-1:0] a_idx_o,
  output logic [$clog2(WORDS)-1:0] b_idx_o,
  output logic [8:0]               OPMODE_o,
  output logic                     CREG_en_o,
  output logic                     res_valid_o,
  output logic                     res_last_o
);

  localparam int L  = ABREG + MREG;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  seq_state_t    state_q, state_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d;
  pipe_ent_t     ent;
  logic          pipe_busy;

  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    ent     = ENT_IDLE;
    issue_o = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: state_d = start_i ? RUN : IDLE;
      RUN: if (operand_rdy_i) begin
        issue_o = 1'b1;
        ent = '{op: (j_q == '0) ? ((CASCADE != 0) ? OP_MPC : OP_MC) : OP_MCSH,
                uses_c: (CASCADE == 0) || (j_q != '0), valid: 1'b1, last: 1'b0};
        state_d = (j_q == LAST) ? FLUSH : RUN;
        j_d = (j_q == LAST) ? j_q : j_q + 1'b1;
      end
      FLUSH: begin
        ent = '{op: OP_CARRY, uses_c: 1'b0, valid: 1'b1, last: 1'b1};
        j_d = '0;
        state_d = (i_q == LAST) ? DRAIN : RUN;
        i_d = (i_q == LAST) ? i_q : i_q + 1'b1;
      end
      DRAIN: if (!pipe_busy) begin
        done_o  = 1'b1;
        state_d = IDLE;
        i_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  pe_au_align_pipe #(
    .LAT   (L),
    .C_TAP (L - CREG)
  ) u_pipe (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .ent_i     (ent),
    .op_o      (OPMODE_o),
    .uses_c_o  (CREG_en_o),
    .valid_o   (res_valid_o),
    .last_o    (res_last_o),
    .busy_o    (pipe_busy)
  );

  assign busy_o  = state_q != IDLE;
  assign a_idx_o = j_q;
  assign b_idx_o = i_q;

endmodule

// File: tb/tb_pe_au_sequencer.sv
// tb_pe_au_sequencer: two sequencer instances (defaults; ABREG=2 with CASCADE) against a
// schedule model that expands each accepted start into per-cycle expected outputs.
module tb_pe_au_sequencer;

  localparam int W  = 4;
  localparam int IW = $clog2(W);
  localparam int NC = 2048;

  localparam logic [8:0] M_HOLD  = 9'b000100000;
  localparam logic [8:0] M_MC    = 9'b110000101;
  localparam logic [8:0] M_MPC   = 9'b000010101;
  localparam logic [8:0] M_MCSH  = 9'b111100101;
  localparam logic [8:0] M_CARRY = 9'b001100000;

  logic clock_i = 1'b0;
  logic reset_n_i = 1'b1;
  logic operand_rdy_i = 1'b0;
  logic [1:0] start_v = '0;
  logic [1:0] busy_v, done_v, issue_v, creg_v, rv_v, rl_v;
  logic [1:0][IW-1:0] aidx_v, bidx_v;
  logic [1:0][8:0] op_v;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int free_at [2];
  logic rdy_seq [NC];
  logic [8:0] e_op [2][NC];
  logic e_busy [2][NC], e_done [2][NC], e_issue [2][NC], e_creg [2][NC], e_rv [2][NC], e_rl [2][NC];
  int e_aidx [2][NC], e_bidx [2][NC];

  always #5 clock_i = ~clock_i;

  pe_au_sequencer #(.WORDS(W)) u_a (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .start_i(start_v[0]), .operand_rdy_i(operand_rdy_i),
    .busy_o(busy_v[0]), .done_o(done_v[0]), .issue_o(issue_v[0]), .a_idx_o(aidx_v[0]),
    .b_idx_o(bidx_v[0]), .OPMODE_o(op_v[0]), .CREG_en_o(creg_v[0]), .res_valid_o(rv_v[0]),
    .res_last_o(rl_v[0]));

  pe_au_sequencer #(.WORDS(W), .ABREG(2), .MREG(1), .CREG(1), .CASCADE(1)) u_b (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .start_i(start_v[1]), .operand_rdy_i(operand_rdy_i),
    .busy_o(busy_v[1]), .done_o(done_v[1]), .issue_o(issue_v[1]), .a_idx_o(aidx_v[1]),
    .b_idx_o(bidx_v[1]), .OPMODE_o(op_v[1]), .CREG_en_o(creg_v[1]), .res_valid_o(rv_v[1]),
    .res_last_o(rl_v[1]));

  task automatic chk(input string tag, input int k, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s inst=%0d cyc=%0d got=%0h exp=%0h", tag, k, cyc, got, exp);
    end
  endtask

  task automatic idle_from(input int c);
    for (int k = 0; k < 2; k++)
      for (int n = c; n < NC; n++) begin
        e_op[k][n] = M_HOLD; e_busy[k][n] = 0; e_done[k][n] = 0; e_issue[k][n] = 0;
        e_creg[k][n] = 0; e_rv[k][n] = 0; e_rl[k][n] = 0; e_aidx[k][n] = 0; e_bidx[k][n] = 0;
      end
  endtask

  task automatic mark(input int k, input int c, input int j, input int i);
    e_busy[k][c] = 1; e_aidx[k][c] = j; e_bidx[k][c] = i;
  endtask

  // Expand a start accepted in cycle s into the whole multiplication's output schedule.
  task automatic plan(input int k, input int s);
    int c, l;
    l = (k == 0) ? 2 : 3;
    c = s + 1;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        while (!rdy_seq[c]) begin mark(k, c, j, i); c++; end
        mark(k, c, j, i);
        e_issue[k][c] = 1;
        e_op[k][c+l] = (j != 0) ? M_MCSH : (k == 1) ? M_MPC : M_MC;
        if (!(j == 0 && k == 1)) e_creg[k][c+l-1] = 1;
        e_rv[k][c+l+1] = 1;
        c++;
      end
      mark(k, c, W - 1, i);
      e_op[k][c+l] = M_CARRY;
      e_rv[k][c+l+1] = 1;
      e_rl[k][c+l+1] = 1;
      c++;
    end
    for (int d = 0; d <= l + 1; d++) mark(k, c + d, 0, W - 1);
    e_done[k][c+l+1] = 1;
    free_at[k] = c + l + 2;
  endtask

  task automatic tick(input logic [1:0] st, input logic rst_n);
    @(posedge clock_i);
    cyc++;
    #1;
    start_v = st;
    operand_rdy_i = rdy_seq[cyc];
    if (rst_n && !reset_n_i) begin
      reset_n_i = 1'b1;
      free_at[0] = cyc;
      free_at[1] = cyc;
    end else if (!rst_n && reset_n_i) begin
      #1;
      reset_n_i = 1'b0;
      idle_from(cyc);
      free_at[0] = NC;
      free_at[1] = NC;
    end
    for (int k = 0; k < 2; k++) if (st[k] && cyc >= free_at[k]) plan(k, cyc);
    @(negedge clock_i);
    for (int k = 0; k < 2; k++) begin
      chk("busy", k, 9'(busy_v[k]), 9'(e_busy[k][cyc]));
      chk("done", k, 9'(done_v[k]), 9'(e_done[k][cyc]));
      chk("issue", k, 9'(issue_v[k]), 9'(e_issue[k][cyc]));
      chk("a_idx", k, 9'(aidx_v[k]), 9'(e_aidx[k][cyc]));
      chk("b_idx", k, 9'(bidx_v[k]), 9'(e_bidx[k][cyc]));
      chk("opmode", k, op_v[k], e_op[k][cyc]);
      chk("creg_en", k, 9'(creg_v[k]), 9'(e_creg[k][cyc]));
      chk("res_valid", k, 9'(rv_v[k]), 9'(e_rv[k][cyc]));
      chk("res_last", k, 9'(rl_v[k]), 9'(e_rl[k][cyc]));
    end
  endtask

  task automatic run(input int n, input logic [1:0] st);
    for (int q = 0; q < n; q++) tick(st, 1'b1);
  endtask

  initial begin
    for (int n = 0; n < NC; n++) rdy_seq[n] = 1'b1;
    idle_from(0);
    free_at[0] = NC;
    free_at[1] = NC;
    #2 reset_n_i = 1'b0;
    tick(2'b00, 1'b0);
    tick(2'b11, 1'b0);
    tick(2'b00, 1'b1);
    tick(2'b00, 1'b1);
    // default pipeline, full-rate operands
    tick(2'b01, 1'b1);
    run(30, 2'b00);
    // deeper A/B pipe with cascade on word 0
    tick(2'b10, 1'b1);
    run(32, 2'b00);
    // three-cycle operand stall at j=2
    for (int n = cyc + 4; n <= cyc + 6; n++) rdy_seq[n] = 1'b0;
    tick(2'b01, 1'b1);
    run(32, 2'b00);
    // start held high across runs, including the done cycle
    run(60, 2'b01);
    run(32, 2'b00);
    // reset in the middle of round 2, then a clean restart
    tick(2'b01, 1'b1);
    run(12, 2'b00);
    tick(2'b00, 1'b0);
    tick(2'b01, 1'b0);
    tick(2'b00, 1'b1);
    tick(2'b01, 1'b1);
    run(30, 2'b00);
    // random operand availability and start pulses on both instances
    for (int n = cyc + 1; n <= cyc + 400; n++) rdy_seq[n] = ($urandom_range(0, 3) != 0);
    for (int q = 0; q < 400; q++)
      tick(($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, 1'b1);
    run(60, 2'b00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
